// File: rtl/radix4_booth_with_regs.sv
// rtl/radix4_booth_with_regs.sv - registered 32x32 signed multiplier using radix-4 Booth recoding
// Operands are registered, reduced by a combinational Booth array, and the 64-bit product is registered.
module radix4_booth_with_regs (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [63:0] result
);

    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [63:0] a_ext;
    logic [32:0] b_ext;
    logic [63:0] pp [16];
    logic [63:0] sum;

    assign a_ext = {{32{a_reg[31]}}, a_reg};
    // Appending a zero below the LSB supplies the implicit b[-1] of the first digit group.
    assign b_ext = {b_reg, 1'b0};

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            pp[i] = '0;
            case (b_ext[2*i +: 3])
                3'b001, 3'b010: pp[i] = a_ext;
                3'b011:         pp[i] = a_ext << 1;
                3'b100:         pp[i] = ~(a_ext << 1) + 64'd1;
                3'b101, 3'b110: pp[i] = ~a_ext + 64'd1;
                default:        pp[i] = '0;
            endcase
        end
    end

    // Each digit weighs 4^i, so its partial product is shifted by 2i before summing modulo 2^64.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + (pp[i] << (2 * i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
        end else if (en) begin
            a_reg  <= a;
            b_reg  <= b;
            result <= sum;
        end
    end

endmodule

// File: tb/tb_radix4_booth_with_regs.sv
// tb/tb_radix4_booth_with_regs.sv - self-checking bench for radix4_booth_with_regs
// Directed vectors with hand-computed products plus stall, streaming and reset sequences.
module tb_radix4_booth_with_regs;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] result;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs [12];

    radix4_booth_with_regs dut (
        .a      (a),
        .b      (b),
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .result (result)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{32'd42,          32'd53,          64'd2226};
        vecs[1]  = '{32'd699049,      32'd13477,       64'd9421083373};
        vecs[2]  = '{-32'sd547623,    32'd2,           -64'sd1095246};
        vecs[3]  = '{-32'sd1,         -32'sd7,         64'd7};
        vecs[4]  = '{32'd10,          32'd1,           64'd10};
        vecs[5]  = '{32'd4,           32'd6,           64'd24};
        vecs[6]  = '{32'd0,           -32'sd5,         64'd0};
        vecs[7]  = '{32'h8000_0000,   32'h8000_0000,   64'd4611686018427387904};
        vecs[8]  = '{32'h8000_0000,   32'h7fff_ffff,   -64'sd4611686016279904256};
        vecs[9]  = '{32'h7fff_ffff,   32'h7fff_ffff,   64'd4611686014132420609};
        vecs[10] = '{-32'sd1,         32'h8000_0000,   64'd2147483648};
        vecs[11] = '{32'd12345,       -32'sd6789,      -64'sd83810205};

        // Reset with en held high and operands already present.
        reset = 1'b1;
        en    = 1'b1;
        a     = 32'd42;
        b     = 32'd53;
        #5;
        check("reset_async", result, 64'd0);
        tick();
        tick();
        check("reset_hold", result, 64'd0);
        reset = 1'b0;
        tick();
        check("first_edge", result, 64'd0);
        tick();
        check("second_edge", result, 64'd2226);

        // Isolated vectors: two enabled edges each.
        for (int i = 0; i < 12; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            tick();
            tick();
            check($sformatf("vec%0d", i), result, vecs[i].p);
        end

        // Back-to-back stream: one new pair per edge, product one edge after its load.
        for (int i = 0; i < 12; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            tick();
            if (i > 0) check($sformatf("stream%0d", i - 1), result, vecs[i - 1].p);
        end
        tick();
        check("stream11", result, vecs[11].p);

        // Enable stall with new inputs applied.
        a = 32'd3;
        b = 32'd5;
        tick();
        tick();
        check("pre_stall", result, 64'd15);
        en = 1'b0;
        a  = 32'd7;
        b  = 32'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d", i), result, 64'd15);
        end
        en = 1'b1;
        tick();
        check("unstall_edge1", result, 64'd15);
        tick();
        check("unstall_edge2", result, 64'd63);

        // Mid-pipeline reset between edges discards in-flight operands.
        a = 32'd100;
        b = 32'd100;
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("mid_reset_async", result, 64'd0);
        tick();
        reset = 1'b0;
        a = 32'd2;
        b = 32'd3;
        tick();
        check("post_reset_edge1", result, 64'd0);
        tick();
        check("post_reset_edge2", result, 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/radix4_booth_with_regs.md
# radix4_booth_with_regs

Registered 32×32 signed multiplier built on radix-4 (modified) Booth recoding. Operands are captured into input registers, multiplied by a single-cycle combinational Booth partial-product array and adder tree, and the 64-bit signed product is captured into an output register. The block is a drop-in pipelined multiplier for datapaths that need a fixed two-cycle latency and a clock-enable stall.

## Interface
- No parameters. Widths are fixed at 32-bit operands and a 64-bit product.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- a  input  32  multiplicand, two's-complement signed.
- b  input  32  multiplier, two's-complement signed; Booth-recoded.
- en  input  1  clock enable for all registers.
- result  output  64  signed product, registered.
- Positional port order is (a, b, clk, reset, en, result).

## Operation
- Stage 1: on a rising clk edge with en=1, a_reg←a and b_reg←b.
- Combinational Booth array:
  - Extend b_reg with an implicit b[-1]=0.
  - Form 16 digit groups {b[2i+1], b[2i], b[2i-1]} for i=0..15.
  - Recode each group: 000/111→0, 001/010→+A, 011→+2A, 100→−2A, 101/110→−A.
  - A is a_reg sign-extended to 64 bits.
  - −A and −2A use two's complement: invert, then +1.
  - Partial product i is shifted left by 2i bits.
  - Sum all 16 partial products modulo 2^64.
- Stage 2: on a rising clk edge with en=1, result←sum.
- Arithmetic is exact for every operand pair, including −2^31 × −2^31 = +2^62, with no overflow.
- With en=0, all registers hold their contents and result stays stable.
- No handshake and no busy or valid signal. A new operand pair can be accepted every enabled cycle (throughput of 1 per cycle).

## Timing
- Reset asserted: a_reg, b_reg and result clear to 0 immediately, without waiting for a clock edge. They stay 0 while reset is high, regardless of en.
- Reset release: the first enabled edge loads the inputs. result becomes valid on the second enabled edge.
- Latency is 2 enabled rising edges from operands to result.
- Operands are sampled only at the edge. Changes between edges have no effect until the next enabled edge.
- en low for N cycles stretches the latency by N cycles, and nothing is lost.
- Reset in mid-pipeline discards in-flight operands, and result returns to 0.
- Holding inputs constant gives a constant result after 2 cycles.
- The combinational path register→Booth array→register must close within one clock period. The target is a 20 ns period.

## Test plan
- Reset, then hold en=1 with a=42, b=53. result=0 during reset, and result=2226 two edges after reset release.
- a=699049, b=13477 → result=9421083373 after 2 cycles. a=−547623, b=2 → result=−1095246.
- a=−1, b=−7 → 7. a=10, b=1 → 10. a=4, b=6 → 24. a=0, b=−5 → 0.
- Extremes:
  - a=b=−2147483648 → 4611686018427387904.
  - a=−2147483648, b=2147483647 → −4611686016279904256.
- Back-to-back: new operand pairs on consecutive enabled edges. Each product appears exactly 2 edges after its operands, one result per cycle.
- Enable and reset:
  - Drop en for 3 cycles with new inputs applied → result holds its old value; the new product appears 2 enabled edges after en returns high.
  - Assert reset between clock edges → result=0 immediately.
